// File: rtl/booth_pkg.sv
// Shared constants, state encoding and sign-extension helper for the Booth
// partial-product accumulator.
package booth_pkg;

  localparam int unsigned X_WIDTH_DEF = 8;
  localparam int unsigned Y_WIDTH_DEF = 8;

  // Working width of sext_pp; products wider than this are not supported.
  localparam int unsigned SEXT_W = 64;

  function automatic int unsigned n_pp_of(input int unsigned y_width);
    return y_width / 2;
  endfunction

  function automatic int unsigned cnt_w_of(input int unsigned n_pp);
    return (n_pp > 1) ? $clog2(n_pp) : 1;
  endfunction

  localparam int unsigned N_PP  = n_pp_of(Y_WIDTH_DEF);
  localparam int unsigned CNT_W = cnt_w_of(N_PP);

  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StAcc  = 2'd1;
  localparam state_t StDone = 2'd2;

  // Sign-extend a pp_w-bit partial product and fold in its +1 correction.
  // Callers truncate the result to their product width.
  function automatic logic [SEXT_W-1:0] sext_pp(input logic [SEXT_W-1:0] pp_in,
                                                input int unsigned       pp_w,
                                                input logic              pp_neg);
    logic [SEXT_W-1:0] v;
    logic              sign;
    sign = pp_in[pp_w-1];
    for (int unsigned i = 0; i < SEXT_W; i++) begin
      v[i] = (i < pp_w) ? pp_in[i] : sign;
    end
    return v + SEXT_W'(pp_neg);
  endfunction

endpackage

// File: rtl/pp_shift_adder.sv
// Combinational weighted add: sum = acc + ((sext(pp) + pp_neg) << 2*cnt),
// all modulo 2^PWidth.
module pp_shift_adder
  import booth_pkg::*;
#(
  parameter int unsigned PpWidth = 10,
  parameter int unsigned PWidth  = 16,
  parameter int unsigned CntW    = 2
) (
  input  logic [PWidth-1:0]  acc_i,
  input  logic [PpWidth-1:0] pp_i,
  input  logic               pp_neg_i,
  input  logic [CntW-1:0]    cnt_i,
  output logic [PWidth-1:0]  sum_o
);

  logic [PWidth-1:0] term;
  logic [CntW:0]     shamt;

  // Radix-4 digit i carries weight 4^i, i.e. a shift of 2*i.
  always_comb begin
    term  = PWidth'(sext_pp(SEXT_W'(pp_i), PpWidth, pp_neg_i));
    shamt = {cnt_i, 1'b0};
    sum_o = acc_i + (term << shamt);
  end

endmodule

// File: rtl/booth_pp_accumulator.sv
// Accumulates serial radix-4 Booth partial products (LS digit first) into a
// signed product and hands it off over a valid/ready handshake.
module booth_pp_accumulator
  import booth_pkg::*;
#(
  parameter int unsigned X_WIDTH = X_WIDTH_DEF,
  parameter int unsigned Y_WIDTH = Y_WIDTH_DEF,
  parameter int unsigned P_WIDTH = X_WIDTH + Y_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [X_WIDTH+1:0] pp,
  input  logic               pp_neg,
  output logic [P_WIDTH-1:0] product,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int unsigned NPp  = n_pp_of(Y_WIDTH);
  localparam int unsigned CntW = cnt_w_of(NPp);
  localparam logic [CntW-1:0] LastCnt = CntW'(NPp - 1);

  state_t             state_q, state_d;
  logic [P_WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic               transfer;
  logic               in_idle;
  logic [P_WIDTH-1:0] add_acc;
  logic [CntW-1:0]    add_cnt;
  logic [P_WIDTH-1:0] sum;

  // The first digit starts from zero at weight 1 regardless of leftover state.
  always_comb begin
    in_idle  = (state_q == StIdle);
    add_acc  = in_idle ? '0 : acc_q;
    add_cnt  = in_idle ? '0 : cnt_q;
    transfer = in_valid && in_ready;
  end

  pp_shift_adder #(
    .PpWidth(X_WIDTH + 2),
    .PWidth (P_WIDTH),
    .CntW   (CntW)
  ) u_adder (
    .acc_i   (add_acc),
    .pp_i    (pp),
    .pp_neg_i(pp_neg),
    .cnt_i   (add_cnt),
    .sum_o   (sum)
  );

  // Next-state: clear overrides everything; gap cycles hold acc and cnt.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (transfer) begin
            acc_d   = sum;
            cnt_d   = CntW'(1);
            state_d = (NPp == 1) ? StDone : StAcc;
          end
        end
        StAcc: begin
          if (transfer) begin
            acc_d = sum;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) state_d = StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_d = StIdle;
            acc_d   = '0;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StIdle;
          acc_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode directly from state so reset takes effect without a clock.
  always_comb begin
    out_valid = (state_q == StDone);
    in_ready  = !out_valid;
    product   = out_valid ? acc_q : '0;
  end

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Self-checking bench for booth_pp_accumulator (X=8, Y=8, four digits).
module tb_booth_pp_accumulator;

  localparam int NPP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  pp = '0;
  logic        pp_neg = 1'b0;
  logic [15:0] product;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [15:0] exp_q[$];
  logic [9:0]  dig_pp[NPP];
  logic        dig_neg[NPP];

  booth_pp_accumulator #(
    .X_WIDTH(8),
    .Y_WIDTH(8),
    .P_WIDTH(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pp       (pp),
    .pp_neg   (pp_neg),
    .product  (product),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] mul_ref(input logic [7:0] x, input logic [7:0] y);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    return p[15:0];
  endfunction

  // Radix-4 Booth recoding of y into (pp, pp_neg) pairs for multiplicand x.
  task automatic gen_digits(input logic [7:0] x, input logic [7:0] y);
    logic signed [9:0] xs;
    logic signed [9:0] x2;
    logic              b0;
    int                d;
    xs = {{2{x[7]}}, x};
    x2 = xs <<< 1;
    for (int i = 0; i < NPP; i++) begin
      b0 = (i == 0) ? 1'b0 : y[2*i-1];
      d  = -2 * int'(y[2*i+1]) + int'(y[2*i]) + int'(b0);
      case (d)
        1:       begin dig_pp[i] = xs;  dig_neg[i] = 1'b0; end
        2:       begin dig_pp[i] = x2;  dig_neg[i] = 1'b0; end
        -1:      begin dig_pp[i] = ~xs; dig_neg[i] = 1'b1; end
        -2:      begin dig_pp[i] = ~x2; dig_neg[i] = 1'b1; end
        default: begin dig_pp[i] = '0;  dig_neg[i] = 1'b0; end
      endcase
    end
  endtask

  // Present one digit until accepted (bounded); leaves in_valid low after.
  task automatic drive_digit(input logic [9:0] v, input logic n);
    int c;
    c = 0;
    in_valid = 1'b1;
    pp = v;
    pp_neg = n;
    while (!in_ready && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    if (in_ready) begin
      @(posedge clk); #1;
    end else begin
      n_vec++; n_err++;
      $display("FAIL drive_digit: in_ready got 0 required 1 within 100 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic send_product(input logic [7:0] x, input logic [7:0] y, input int max_gap);
    gen_digits(x, y);
    exp_q.push_back(mul_ref(x, y));
    for (int i = 0; i < NPP; i++) begin
      drive_digit(dig_pp[i], dig_neg[i]);
      if (i < NPP - 1 && max_gap > 0) repeat ($urandom_range(max_gap, 0)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_valid(output bit ok);
    int c;
    c = 0;
    while (!out_valid && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    ok = out_valid;
  endtask

  task automatic release_product();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_vec++; if (product !== 16'h0000) begin n_err++;
      $display("FAIL reset_product: got %h required 0000", product); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Checks latency (valid right after the 4th digit), value, in_ready and release.
  task automatic test_basic(input string name, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] e;
    send_product(x, y, 0);
    e = exp_q.pop_front();
    n_vec++; if (out_valid !== 1'b1) begin n_err++;
      $display("FAIL %s_latency: out_valid got %b required 1", name, out_valid); end
    n_vec++; if (product !== e) begin n_err++;
      $display("FAIL %s_product: got %h required %h", name, product, e); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++;
      $display("FAIL %s_in_ready_done: got %b required 0", name, in_ready); end
    release_product();
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++;
      $display("FAIL %s_release: out_valid/in_ready got %b%b required 01",
               name, out_valid, in_ready); end
  endtask

  task automatic test_gaps();
    logic [15:0] e;
    bit          ok;
    gen_digits(8'd7, 8'hFF);
    exp_q.push_back(mul_ref(8'd7, 8'hFF));
    for (int i = 0; i < NPP; i++) begin
      drive_digit(dig_pp[i], dig_neg[i]);
      if (i < NPP - 1) repeat ($urandom_range(3, 1)) begin
        n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++;
          $display("FAIL gaps_hold: in_ready/out_valid got %b%b required 10",
                   in_ready, out_valid); end
        @(posedge clk); #1;
      end
    end
    wait_valid(ok);
    e = exp_q.pop_front();
    n_vec++; if (!ok || product !== e) begin n_err++;
      $display("FAIL gaps_product: got %h valid %b required %h", product, ok, e); end
    release_product();
  endtask

  task automatic test_backpressure();
    logic [15:0] e;
    bit          ok;
    send_product(8'hFD, 8'd9, 0);
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      pp = 10'h155;
      pp_neg = 1'b1;
      n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || product !== e) begin n_err++;
        $display("FAIL bp_hold: rdy/vld/product got %b%b %h required 01 %h",
                 in_ready, out_valid, product, e); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    release_product();
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++;
      $display("FAIL bp_release: vld/rdy got %b%b required 01", out_valid, in_ready); end
    send_product(8'hFA, 8'd11, 0);
    wait_valid(ok);
    e = exp_q.pop_front();
    n_vec++; if (!ok || product !== e) begin n_err++;
      $display("FAIL bp_next_product: got %h required %h", product, e); end
    release_product();
  endtask

  task automatic test_clear();
    logic [15:0] e;
    bit          ok;
    gen_digits(8'd100, 8'hB3);
    drive_digit(dig_pp[0], dig_neg[0]);
    drive_digit(dig_pp[1], dig_neg[1]);
    clear = 1'b1;
    in_valid = 1'b1;
    pp = 10'h0AA;
    pp_neg = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++;
      $display("FAIL clear_acc: rdy/vld got %b%b required 10", in_ready, out_valid); end
    send_product(8'd3, 8'd2, 0);
    wait_valid(ok);
    e = exp_q.pop_front();
    n_vec++; if (!ok || product !== e) begin n_err++;
      $display("FAIL clear_then_3x2: got %h required %h", product, e); end
    release_product();
    // Clear while a finished product is waiting.
    send_product(8'd11, 8'd13, 0);
    e = exp_q.pop_front();
    n_vec++; if (out_valid !== 1'b1 || product !== e) begin n_err++;
      $display("FAIL clear_done_pre: got %h required %h", product, e); end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    n_vec++; if (out_valid !== 1'b0 || product !== 16'h0000) begin n_err++;
      $display("FAIL clear_done: vld/product got %b %h required 0 0000", out_valid, product); end
    send_product(8'hFF, 8'hFF, 0);
    wait_valid(ok);
    e = exp_q.pop_front();
    n_vec++; if (!ok || product !== e) begin n_err++;
      $display("FAIL clear_done_next: got %h required %h", product, e); end
    release_product();
  endtask

  task automatic test_async_reset();
    logic [15:0] e;
    bit          ok;
    gen_digits(8'd50, 8'd60);
    drive_digit(dig_pp[0], dig_neg[0]);
    drive_digit(dig_pp[1], dig_neg[1]);
    #2 rst = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 16'h0) begin n_err++;
      $display("FAIL arst_acc: vld/rdy/product got %b%b %h required 01 0000",
               out_valid, in_ready, product); end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    send_product(8'd9, 8'hF7, 0);
    wait_valid(ok);
    e = exp_q.pop_front();
    n_vec++; if (!ok || product !== e) begin n_err++;
      $display("FAIL arst_fresh_product: got %h required %h", product, e); end
    #2 rst = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 16'h0) begin n_err++;
      $display("FAIL arst_done: vld/rdy/product got %b%b %h required 01 0000",
               out_valid, in_ready, product); end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] xs[4] = '{8'd17, 8'h81, 8'd127, 8'hC4};
    logic [7:0] ys[4] = '{8'd29, 8'h7F, 8'h80, 8'hE9};
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) send_product(xs[i], ys[i], 0);
      end
      begin
        int          last;
        bit          ok;
        logic [15:0] e;
        last = 0;
        for (int i = 0; i < 4; i++) begin
          wait_valid(ok);
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
          n_vec++; if (!ok || product !== e) begin n_err++;
            $display("FAIL b2b_product%0d: got %h required %h", i, product, e); end
          if (i > 0) begin
            n_vec++; if (cyc - last !== NPP + 1) begin n_err++;
              $display("FAIL b2b_spacing%0d: got %0d cycles required %0d",
                       i, cyc - last, NPP + 1); end
          end
          last = cyc;
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] e;
    logic [7:0]  x;
    logic [7:0]  y;
    bit          ok;
    for (int k = 0; k < 12; k++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      send_product(x, y, 2);
      wait_valid(ok);
      e = exp_q.pop_front();
      repeat ($urandom_range(2, 0)) begin
        @(posedge clk); #1;
      end
      n_vec++; if (!ok || product !== e) begin n_err++;
        $display("FAIL rand_%0d: %h*%h got %h required %h", k, x, y, product, e); end
      release_product();
    end
  endtask

  initial begin
    test_reset();
    test_basic("x5y3", 8'd5, 8'd3);
    test_basic("min_min", 8'h80, 8'h80);
    test_gaps();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
